// File: rtl/clk_div_bank_pkg.sv
// Shared types and constants for the clock-pattern generator bank.
// Holds the channel config record, FSM states and reset-default helpers.
package clk_div_bank_pkg;

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned RST_DIV  = 5;
   localparam int unsigned RST_HIGH = 2;

   typedef enum logic {
      S_SETTLE = 1'b0,
      S_LOCKED = 1'b1
   } state_e;

   typedef struct packed {
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] high;
      logic [CNT_W-1:0] phase;
      logic             en;
   } chan_cfg_t;

   // Reset-default channel config: given divide and high time, phase 0, enabled.
   function automatic chan_cfg_t def_cfg(input int unsigned div, input int unsigned high);
      return '{div: CNT_W'(div), high: CNT_W'(high), phase: '0, en: 1'b1};
   endfunction

   // A waveform is only meaningful when high and phase both fit inside one period.
   function automatic logic cfg_bad(input logic [CNT_W-1:0] div,
                                    input logic [CNT_W-1:0] high,
                                    input logic [CNT_W-1:0] phase);
      return (div < CNT_W'(2)) || (high == '0) || (high >= div) || (phase >= div);
   endfunction

endpackage

// File: rtl/clk_div_bank_chan.sv
// One divider channel: period counter, lock-time phase load and
// registered waveform/strobe outputs.
module clk_div_chan
   import clk_div_bank_pkg::*;
(
   input  logic      refclk,
   input  logic      rst,
   input  chan_cfg_t cfg,
   input  logic      load,
   input  logic      run,
   output logic      outclk,
   output logic      outstb
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             outclk_q, outclk_d;
   logic             outstb_q, outstb_d;
   logic [CNT_W-1:0] load_val;

   // (div - phase) mod div without a divider; phase < div is guaranteed upstream
   assign load_val = (cfg.phase == '0) ? '0 : (cfg.div - cfg.phase);

   always_comb begin
      cnt_d    = '0;
      outclk_d = 1'b0;
      outstb_d = 1'b0;
      if (cfg.en && (load || run)) begin
         if (load) begin
            cnt_d = load_val;
         end else if (cnt_q >= (cfg.div - CNT_W'(1))) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         outclk_d = (cnt_d < cfg.high);
         outstb_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         outclk_q <= 1'b0;
         outstb_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         outclk_q <= outclk_d;
         outstb_q <= outstb_d;
      end
   end

   assign outclk = outclk_q;
   assign outstb = outstb_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel phase-aligned divided-clock and strobe generator with a
// settle/lock FSM and shadow/active configuration banks.
module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter  int unsigned NUM_CLOCKS  = 4,
   parameter  int unsigned LOCK_CYCLES = 64,
   parameter  int unsigned DEF_DIV     = RST_DIV,
   parameter  int unsigned DEF_HIGH    = RST_HIGH,
   localparam int unsigned CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_chan,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [CNT_W-1:0]      cfg_high,
   input  logic [CNT_W-1:0]      cfg_phase,
   input  logic                  cfg_en,
   input  logic                  cfg_apply,
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outstb,
   output logic                  locked
);

   localparam int unsigned SET_W   = $clog2(LOCK_CYCLES + 1);
   localparam chan_cfg_t   RST_CFG = def_cfg(DEF_DIV, DEF_HIGH);

   state_e     state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   chan_cfg_t  shadow_q [NUM_CLOCKS];
   chan_cfg_t  shadow_d [NUM_CLOCKS];
   chan_cfg_t  active_q [NUM_CLOCKS];
   chan_cfg_t  active_d [NUM_CLOCKS];
   logic       locked_q, locked_d;
   logic       ready_q, ready_d;
   logic       err_q, err_d;
   logic       chan_load, chan_run;
   logic       wr_fire, wr_bad, chan_bad;
   chan_cfg_t  wr_cfg;

   assign wr_cfg   = '{div: cfg_div, high: cfg_high, phase: cfg_phase, en: cfg_en};
   assign chan_bad = (32'(cfg_chan) >= NUM_CLOCKS);
   assign wr_fire  = cfg_valid & ready_q;
   assign wr_bad   = chan_bad | cfg_bad(cfg_div, cfg_high, cfg_phase);

   // Write validation, shadow update, and settle/lock sequencing
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      chan_load = 1'b0;
      chan_run  = 1'b0;
      err_d     = wr_fire & wr_bad;

      if (wr_fire && !wr_bad) begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == CH_W'(i)) shadow_d[i] = wr_cfg;
         end
      end

      case (state_q)
         S_SETTLE: begin
            if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
               state_d   = S_LOCKED;
               settle_d  = '0;
               chan_load = 1'b1;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         S_LOCKED: begin
            if (cfg_apply) begin
               // includes a write accepted on this same edge
               active_d = shadow_d;
               state_d  = S_SETTLE;
               settle_d = '0;
            end else begin
               chan_run = 1'b1;
            end
         end
         default: begin
            state_d  = S_SETTLE;
            settle_d = '0;
         end
      endcase

      locked_d = (state_d == S_LOCKED);
      ready_d  = (state_d == S_LOCKED);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q  <= S_SETTLE;
         settle_q <= '0;
         locked_q <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            shadow_q[i] <= RST_CFG;
            active_q[i] <= RST_CFG;
         end
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         locked_q <= locked_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
      clk_div_chan u_chan (
         .refclk (refclk),
         .rst    (rst),
         .cfg    (active_q[g]),
         .load   (chan_load),
         .run    (chan_run),
         .outclk (outclk[g]),
         .outstb (outstb[g])
      );
   end

   assign locked    = locked_q;
   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized and directed bench for clk_div_bank against an arithmetic
// model of the lock timing and per-channel waveforms.
module tb_clk_div_bank;
   import clk_div_bank_pkg::*;

   localparam int N    = 4;
   localparam int LOCK = 64;

   logic             refclk;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_chan;
   logic [CNT_W-1:0] cfg_div, cfg_high, cfg_phase;
   logic             cfg_en;
   logic             cfg_apply;
   logic             cfg_err;
   logic [N-1:0]     outclk, outstb;
   logic             locked;

   clk_div_bank #(.NUM_CLOCKS(N), .LOCK_CYCLES(LOCK), .DEF_DIV(5), .DEF_HIGH(2)) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .cfg_en    (cfg_en),
      .cfg_apply (cfg_apply),
      .cfg_err   (cfg_err),
      .outclk    (outclk),
      .outstb    (outstb),
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model: configs plus "cycles since settle start / since lock"
   int sh_div [N], sh_high [N], sh_ph [N];
   bit sh_en  [N];
   int ac_div [N], ac_high [N], ac_ph [N];
   bit ac_en  [N];
   bit m_locked, m_err;
   int m_settle, m_t;
   logic [N-1:0] hist [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         sh_div[c] = 5; sh_high[c] = 2; sh_ph[c] = 0; sh_en[c] = 1'b1;
         ac_div[c] = 5; ac_high[c] = 2; ac_ph[c] = 0; ac_en[c] = 1'b1;
      end
      m_locked = 1'b0; m_err = 1'b0; m_settle = 0; m_t = 0;
   endtask

   task automatic model_edge();
      bit fire, bad;
      int d, h, p;
      d = int'(cfg_div); h = int'(cfg_high); p = int'(cfg_phase);
      fire  = cfg_valid && m_locked;
      bad   = (int'(cfg_chan) >= N) || (d < 2) || (h == 0) || (h >= d) || (p >= d);
      m_err = fire && bad;
      if (fire && !bad) begin
         sh_div[cfg_chan] = d; sh_high[cfg_chan] = h;
         sh_ph[cfg_chan] = p;  sh_en[cfg_chan] = cfg_en;
      end
      if (!m_locked) begin
         m_settle++;
         if (m_settle == LOCK) begin m_locked = 1'b1; m_t = 0; end
      end else if (cfg_apply) begin
         ac_div = sh_div; ac_high = sh_high; ac_ph = sh_ph; ac_en = sh_en;
         m_locked = 1'b0; m_settle = 0;
      end else begin
         m_t++;
      end
   endtask

   task automatic check_all();
      logic [N-1:0] eclk, estb;
      int cnt;
      eclk = '0; estb = '0;
      for (int c = 0; c < N; c++) begin
         if (m_locked && ac_en[c]) begin
            cnt = ((ac_div[c] - ac_ph[c]) % ac_div[c] + m_t) % ac_div[c];
            eclk[c] = (cnt < ac_high[c]);
            estb[c] = (cnt == 0);
         end
      end
      chk("locked", 32'(locked), 32'(m_locked));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_locked));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("outclk", 32'(outclk), 32'(eclk));
      chk("outstb", 32'(outstb), 32'(estb));
   endtask

   task automatic step();
      model_edge();
      @(posedge refclk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      cfg_valid = 1'b0; cfg_apply = 1'b0; cfg_chan = '0;
      cfg_div = '0; cfg_high = '0; cfg_phase = '0; cfg_en = 1'b0;
   endtask

   task automatic idle(input int n);
      idle_inputs();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input int ch, input int d, input int h, input int p,
                     input bit en, input bit apply);
      cfg_valid = 1'b1; cfg_chan = 2'(ch); cfg_div = CNT_W'(d);
      cfg_high = CNT_W'(h); cfg_phase = CNT_W'(p); cfg_en = en; cfg_apply = apply;
      step();
      idle_inputs();
   endtask

   task automatic apply();
      idle_inputs();
      cfg_apply = 1'b1;
      step();
      idle_inputs();
   endtask

   // records outclk from the current (lock) cycle onwards
   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         hist[i] = outclk;
         step();
      end
   endtask

   function automatic logic [7:0] pat_of(input int ch, input int n);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < n; i++) p = {p[6:0], hist[i][ch]};
      return p;
   endfunction

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge refclk); @(posedge refclk); #1;
      check_all();
      rst = 1'b0;

      // defaults: lock on the 64th edge, all channels 1,1,0,0,0
      idle(LOCK - 1);
      chk("prelock", 32'(locked), 32'd0);
      idle(1);
      chk("lock_at_64", 32'(locked), 32'd1);
      record(8);
      chk("ch0_default", 32'(pat_of(0, 5)), 32'b11000);
      chk("ch3_default", 32'(pat_of(3, 5)), 32'b11000);

      // ch1 {4,2,1,1} then apply
      wr(1, 4, 2, 1, 1'b1, 1'b0);
      apply();
      chk("unlock_after_apply", 32'(locked), 32'd0);
      idle(LOCK);
      record(8);
      chk("ch1_phase1", 32'(pat_of(1, 4)), 32'b0110);
      chk("ch0_kept", 32'(pat_of(0, 5)), 32'b11000);

      // rejected writes leave the config alone
      wr(1, 5, 5, 0, 1'b1, 1'b0);
      chk("err_high_eq_div", 32'(cfg_err), 32'd1);
      idle(1);
      chk("err_one_cycle", 32'(cfg_err), 32'd0);
      wr(0, 1, 1, 0, 1'b1, 1'b0);
      wr(2, 6, 0, 0, 1'b1, 1'b0);
      wr(3, 6, 2, 6, 1'b1, 1'b0);
      apply();
      idle(LOCK);
      record(8);
      chk("ch1_after_rej", 32'(pat_of(1, 4)), 32'b0110);
      chk("ch0_after_rej", 32'(pat_of(0, 5)), 32'b11000);

      // write and apply on the same edge
      wr(2, 2, 1, 0, 1'b1, 1'b1);
      idle(LOCK);
      record(8);
      chk("ch2_same_cycle", 32'(pat_of(2, 4)), 32'b1010);

      // disable ch3
      wr(3, 5, 2, 0, 1'b0, 1'b0);
      apply();
      idle(LOCK);
      record(8);
      chk("ch3_disabled", 32'(pat_of(3, 8)), 32'd0);
      chk("ch2_unchanged", 32'(pat_of(2, 4)), 32'b1010);

      // randomized writes and applies
      for (int i = 0; i < 3000; i++) begin
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_chan  = 2'($urandom_range(0, N - 1));
         cfg_div   = CNT_W'($urandom_range(0, 9));
         cfg_high  = CNT_W'($urandom_range(0, 9));
         cfg_phase = CNT_W'($urandom_range(0, 9));
         cfg_en    = ($urandom_range(0, 4) != 0);
         cfg_apply = ($urandom_range(0, 79) == 0);
         step();
      end
      idle(LOCK + 10);

      // asynchronous reset mid-cycle
      #($urandom_range(1, 15));
      rst = 1'b1;
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_outclk", 32'(outclk), 32'd0);
      chk("rst_outstb", 32'(outstb), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      model_reset();
      @(posedge refclk); @(posedge refclk); #1;
      check_all();
      rst = 1'b0;
      idle(LOCK - 1);
      chk("prelock_2", 32'(locked), 32'd0);
      idle(1);
      chk("lock_at_64_2", 32'(locked), 32'd1);
      record(8);
      chk("ch0_default_2", 32'(pat_of(0, 5)), 32'b11000);
      chk("ch3_default_2", 32'(pat_of(3, 5)), 32'b11000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
